fly_wave_scheduler: RTL and testbench
=====================================

# fly_wave_scheduler

Wave sequencer and kill bookkeeper for the fly-enemy formation. It pulses `reset_fly` to spawn each wave and generates the `move_tick` cadence, which shortens as waves advance. It owns the kill mask that the top level ANDs with `fly_alive_flat` for rendering, and it tracks score, lives and game-over. It sits between the collision logic (kill reports) and the fly mover/renderer, all in the `clk25` domain.

## Interface
- `N_FLY`, 17, number of flies (alive vector width)
- `BASE_PERIOD`, 32768, move-tick period in cycles for wave 0
- `PERIOD_STEP`, 4096, period reduction per wave
- `MIN_PERIOD`, 4096, floor on move-tick period
- `START_LIVES`, 3, lives loaded at game start (2-bit counter, max 3)
- `CLEAR_DELAY`, 2500000, idle cycles between a cleared wave and the next spawn
- `clk25`  in  1  25 MHz pixel/system clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  start/restart request, sampled per cycle
- `fly_alive_flat`  in  N_FLY  alive flags from the fly mover
- `kill_valid`  in  1  collision logic reports a hit this cycle
- `kill_idx`  in  5  index of the fly that was hit
- `reset_fly`  out  1  one-cycle spawn pulse to the mover
- `move_tick`  out  1  one-cycle movement strobe
- `kill_mask`  out  N_FLY  1 = fly destroyed by player
- `wave`  out  4  current wave number
- `score`  out  16  kills, saturating
- `lives`  out  2  remaining lives
- `game_over`  out  1  high in OVER state
- `state`  out  3  FSM state (debug)

## Operation
- States: IDLE=0, SPAWN=1, ARM=2, ACTIVE=3, CLEAR=4, OVER=5.
- IDLE: `start`=1 → SPAWN. Entering play from IDLE or OVER clears score and wave to 0 and loads lives=START_LIVES.
- SPAWN (1 cycle): `reset_fly`=1, `kill_mask` cleared, period latched = max(BASE_PERIOD − wave·PERIOD_STEP, MIN_PERIOD) using 20-bit arithmetic with no underflow. → ARM.
- ARM (1 cycle): the mover reloads its flags; `prev_alive` ← `fly_alive_flat`; tick counter ← 0. → ACTIVE.
- ACTIVE:
  - Tick counter increments. At count == period−1, `move_tick`=1 and the counter returns to 0.
  - Kill accepted iff `kill_valid`, kill_idx < N_FLY, `fly_alive_flat[idx]`=1 and `kill_mask[idx]`=0. On acceptance, mask bit set next cycle and score+1, saturating at 0xFFFF. Rejected kills are ignored silently.
  - Escape: `prev_alive & ~fly_alive_flat & ~kill_mask`. lives −= popcount of the escapes, saturating at 0. `prev_alive` updates every cycle.
  - lives reaching 0 → OVER, which has priority over CLEAR.
  - Else, when `(fly_alive_flat & ~kill_mask) == 0` → CLEAR.
- CLEAR: counts CLEAR_DELAY cycles. Then wave+1, saturating at 15 → SPAWN.
- OVER: `game_over`=1, outputs frozen. `start` → SPAWN with game-start init.
- `start` is ignored outside IDLE and OVER.

## Timing
- Reset values: state=IDLE, `reset_fly`=0, `move_tick`=0, `kill_mask`=0, wave=0, score=0, lives=START_LIVES, `game_over`=0. Internal counters and `prev_alive` are 0.
- `start` → `reset_fly` high on the next cycle (state=SPAWN). The first `move_tick` comes period cycles after ACTIVE entry.
- A kill presented at cycle t appears in `kill_mask`/score at t+1.
- A kill and an alive fall on the same fly in the same cycle is a kill (alive still 1 at t). An alive fall at t+1 is then masked, so no escape is counted.
- Wave clear detection is combinational on inputs and is registered into CLEAR one cycle later.
- `reset_n` low mid-wave returns to reset values immediately; `reset_fly` is not pulsed until the next `start`.
- All outputs are registered.

## Configuration
- `FLY_SCHED_BONUS_LIFE_EN` defined: a wave cleared with zero escapes grants +1 life on the CLEAR→SPAWN transition, saturating at 3.
- Undefined: lives never increase during play.

## Test plan
- Reset then `start`: `reset_fly` pulses exactly 1 cycle. With BASE_PERIOD=16, the first `move_tick` occurs 16 cycles after ACTIVE entry and then every 16 cycles.
- Kill idx 3, then idx 3 again, then idx 20: `kill_mask`=0x00008 and score=1. The duplicate and the out-of-range kill are ignored.
- Drop alive bits 0 and 1 in the same cycle (not killed), lives=3: lives=1. Drop bit 2: lives=0 and state=OVER next cycle.
- Kill all 17 flies: CLEAR entered. After CLEAR_DELAY (set to 8), wave=1, `reset_fly` pulses, and the period becomes 16−4=12 (STEP=4, MIN=8). At wave 3 the period is clamped to 8.
- Simultaneous kill idx 5 and alive[5] falling: score+1, lives unchanged. Assert `reset_n` mid-ACTIVE: every output returns to its reset value.
- With `FLY_SCHED_BONUS_LIFE_EN`, clear a wave at lives=2 with no escapes: lives=3. Repeat at lives=3: lives stays 3.

Source files
------------

// File: rtl/fly_wave_scheduler.sv
// Wave sequencer and kill bookkeeper for the fly-enemy formation.
// It spawns waves, generates the move_tick cadence, and tracks kills, score, lives and game-over.
// Optional feature macro: FLY_SCHED_BONUS_LIFE_EN. When it is defined, a wave cleared with no
// escapes grants one extra life.
module fly_wave_scheduler #(
  parameter int unsigned N_FLY       = 17,
  parameter int unsigned BASE_PERIOD = 32768,
  parameter int unsigned PERIOD_STEP = 4096,
  parameter int unsigned MIN_PERIOD  = 4096,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned CLEAR_DELAY = 2500000
) (
  input  logic             clk25,
  input  logic             reset_n,
  input  logic             start,
  input  logic [N_FLY-1:0] fly_alive_flat,
  input  logic             kill_valid,
  input  logic [4:0]       kill_idx,
  output logic             reset_fly,
  output logic             move_tick,
  output logic [N_FLY-1:0] kill_mask,
  output logic [3:0]       wave,
  output logic [15:0]      score,
  output logic [1:0]       lives,
  output logic             game_over,
  output logic [2:0]       state
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSpawn  = 3'd1;
  localparam logic [2:0] StArm    = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StClear  = 3'd4;
  localparam logic [2:0] StOver   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [3:0]       wave_q, wave_d;
  logic [15:0]      score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic [N_FLY-1:0] kill_mask_q, kill_mask_d;
  logic [N_FLY-1:0] prev_alive_q, prev_alive_d;
  logic [19:0]      tick_cnt_q, tick_cnt_d;
  logic [19:0]      period_q, period_d;
  logic [31:0]      clear_cnt_q, clear_cnt_d;
  logic             escaped_q, escaped_d;
  logic             reset_fly_q, reset_fly_d;
  logic             move_tick_q, move_tick_d;
  logic             game_over_q, game_over_d;

  logic [N_FLY-1:0] kill_onehot;
  logic             kill_ok;
  logic [N_FLY-1:0] escape;
  logic [7:0]       esc_cnt;
  logic [1:0]       lives_esc;
  logic [19:0]      step_total;
  logic [19:0]      spawn_period;

  // Decode the reported kill index; out-of-range indices decode to nothing.
  always_comb begin
    kill_onehot = '0;
    if (32'(kill_idx) < N_FLY) begin
      kill_onehot[kill_idx] = 1'b1;
    end
  end

  assign kill_ok = kill_valid & (|(kill_onehot & fly_alive_flat & ~kill_mask_q));

  // Flies that vanished without being shot count as escapes; popcount them.
  always_comb begin
    escape  = prev_alive_q & ~fly_alive_flat & ~kill_mask_q;
    esc_cnt = '0;
    for (int i = 0; i < int'(N_FLY); i++) begin
      esc_cnt = esc_cnt + 8'(escape[i]);
    end
    if ({6'd0, lives_q} <= esc_cnt) begin
      lives_esc = 2'd0;
    end else begin
      lives_esc = lives_q - esc_cnt[1:0];
    end
  end

  // Period for the upcoming wave, clamped at the floor without wrapping below zero.
  always_comb begin
    step_total = 20'(wave_q) * 20'(PERIOD_STEP);
    if (step_total >= 20'(BASE_PERIOD)) begin
      spawn_period = 20'(MIN_PERIOD);
    end else if ((20'(BASE_PERIOD) - step_total) < 20'(MIN_PERIOD)) begin
      spawn_period = 20'(MIN_PERIOD);
    end else begin
      spawn_period = 20'(BASE_PERIOD) - step_total;
    end
  end

  // Next-state logic for the wave FSM and all bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    wave_d       = wave_q;
    score_d      = score_q;
    lives_d      = lives_q;
    kill_mask_d  = kill_mask_q;
    prev_alive_d = prev_alive_q;
    tick_cnt_d   = tick_cnt_q;
    period_d     = period_q;
    clear_cnt_d  = clear_cnt_q;
    escaped_d    = escaped_q;
    move_tick_d  = 1'b0;

    case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StSpawn;
          score_d = '0;
          wave_d  = '0;
          lives_d = 2'(START_LIVES);
        end
      end
      StSpawn: begin
        kill_mask_d = '0;
        period_d    = spawn_period;
        escaped_d   = 1'b0;
        state_d     = StArm;
      end
      StArm: begin
        prev_alive_d = fly_alive_flat;
        tick_cnt_d   = '0;
        state_d      = StActive;
      end
      StActive: begin
        prev_alive_d = fly_alive_flat;
        if (tick_cnt_q == period_q - 20'd1) begin
          move_tick_d = 1'b1;
          tick_cnt_d  = '0;
        end else begin
          tick_cnt_d = tick_cnt_q + 20'd1;
        end
        if (kill_ok) begin
          kill_mask_d = kill_mask_q | kill_onehot;
          if (score_q != 16'hFFFF) begin
            score_d = score_q + 16'd1;
          end
        end
        if (|escape) begin
          escaped_d = 1'b1;
        end
        lives_d = lives_esc;
        // Losing the last life wins over a simultaneous wave clear.
        if (lives_esc == 2'd0) begin
          state_d = StOver;
        end else if (~|(fly_alive_flat & ~kill_mask_q)) begin
          state_d     = StClear;
          clear_cnt_d = '0;
        end
      end
      StClear: begin
        if (clear_cnt_q == CLEAR_DELAY - 1) begin
          state_d = StSpawn;
          if (wave_q != 4'd15) begin
            wave_d = wave_q + 4'd1;
          end
`ifdef FLY_SCHED_BONUS_LIFE_EN
          if (!escaped_q && lives_q != 2'd3) begin
            lives_d = lives_q + 2'd1;
          end
`endif
        end else begin
          clear_cnt_d = clear_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    reset_fly_d = (state_d == StSpawn);
    game_over_d = (state_d == StOver);
  end

  // State and output registers.
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wave_q       <= '0;
      score_q      <= '0;
      lives_q      <= 2'(START_LIVES);
      kill_mask_q  <= '0;
      prev_alive_q <= '0;
      tick_cnt_q   <= '0;
      period_q     <= '0;
      clear_cnt_q  <= '0;
      escaped_q    <= 1'b0;
      reset_fly_q  <= 1'b0;
      move_tick_q  <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wave_q       <= wave_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      kill_mask_q  <= kill_mask_d;
      prev_alive_q <= prev_alive_d;
      tick_cnt_q   <= tick_cnt_d;
      period_q     <= period_d;
      clear_cnt_q  <= clear_cnt_d;
      escaped_q    <= escaped_d;
      reset_fly_q  <= reset_fly_d;
      move_tick_q  <= move_tick_d;
      game_over_q  <= game_over_d;
    end
  end

  assign reset_fly = reset_fly_q;
  assign move_tick = move_tick_q;
  assign kill_mask = kill_mask_q;
  assign wave      = wave_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule

// File: tb/tb_fly_wave_scheduler.sv
// Directed bench for fly_wave_scheduler with a short period and clear delay.
module tb_fly_wave_scheduler;

  localparam logic [16:0] ALL = 17'h1FFFF;

  logic        clk25 = 1'b0;
  logic        reset_n;
  logic        start;
  logic [16:0] fly_alive_flat;
  logic        kill_valid;
  logic [4:0]  kill_idx;
  logic        reset_fly;
  logic        move_tick;
  logic [16:0] kill_mask;
  logic [3:0]  wave;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #20 clk25 = ~clk25;

  fly_wave_scheduler #(
    .N_FLY      (17),
    .BASE_PERIOD(16),
    .PERIOD_STEP(4),
    .MIN_PERIOD (8),
    .START_LIVES(3),
    .CLEAR_DELAY(8)
  ) dut (
    .clk25         (clk25),
    .reset_n       (reset_n),
    .start         (start),
    .fly_alive_flat(fly_alive_flat),
    .kill_valid    (kill_valid),
    .kill_idx      (kill_idx),
    .reset_fly     (reset_fly),
    .move_tick     (move_tick),
    .kill_mask     (kill_mask),
    .wave          (wave),
    .score         (score),
    .lives         (lives),
    .game_over     (game_over),
    .state         (state)
  );

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  // Kills every fly in turn, then walks through CLEAR into the next SPAWN.
  task automatic clear_wave(input logic [3:0] exp_wave);
    for (int i = 0; i < 17; i++) begin
      kill_valid = 1'b1;
      kill_idx   = 5'(i);
      step();
    end
    kill_valid = 1'b0;
    step();
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL clear_entry: state=%0d required=4", state);
    end
    repeat (7) step();
    n_checks++;
    if (state !== 3'd4) begin
      n_fail++;
      $display("FAIL clear_hold: state=%0d required=4", state);
    end
    step();
    n_checks++;
    if (state !== 3'd1 || wave !== exp_wave || reset_fly !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_respawn: state=%0d wave=%0d reset_fly=%b required 1/%0d/1",
               state, wave, reset_fly, exp_wave);
    end
    fly_alive_flat = ALL;
  endtask

  // From SPAWN: go to ACTIVE and check two full move_tick periods.
  task automatic check_period(input int p);
    step();
    step();
    for (int i = 1; i <= 2 * p; i++) begin
      step();
      n_checks++;
      if (move_tick !== ((i % p) == 0)) begin
        n_fail++;
        $display("FAIL period_%0d: cycle %0d move_tick=%b required=%b", p, i, move_tick,
                 ((i % p) == 0));
      end
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    start          = 1'b0;
    kill_valid     = 1'b0;
    kill_idx       = '0;
    fly_alive_flat = ALL;
    repeat (3) step();
    n_checks++;
    if ({state, reset_fly, move_tick, kill_mask, wave, score, lives, game_over} !==
        {3'd0, 1'b0, 1'b0, 17'd0, 4'd0, 16'd0, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d rf=%b mt=%b mask=%h wave=%0d score=%0d lives=%0d go=%b",
               state, reset_fly, move_tick, kill_mask, wave, score, lives, game_over);
    end
    reset_n = 1'b1;
    step();
    n_checks++;
    if (state !== 3'd0 || reset_fly !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: state=%0d reset_fly=%b required 0/0", state, reset_fly);
    end
  endtask

  task automatic test_start_tick();
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (state !== 3'd1 || reset_fly !== 1'b1) begin
      n_fail++;
      $display("FAIL start_spawn: state=%0d reset_fly=%b required 1/1", state, reset_fly);
    end
    step();
    n_checks++;
    if (state !== 3'd2 || reset_fly !== 1'b0) begin
      n_fail++;
      $display("FAIL spawn_pulse_width: state=%0d reset_fly=%b required 2/0", state, reset_fly);
    end
    step();
    n_checks++;
    if (state !== 3'd3) begin
      n_fail++;
      $display("FAIL active_entry: state=%0d required=3", state);
    end
    for (int i = 1; i <= 32; i++) begin
      step();
      n_checks++;
      if (move_tick !== ((i % 16) == 0)) begin
        n_fail++;
        $display("FAIL tick_16: cycle %0d move_tick=%b required=%b", i, move_tick,
                 ((i % 16) == 0));
      end
    end
  endtask

  task automatic test_kill();
    kill_valid = 1'b1;
    kill_idx   = 5'd3;
    step();
    n_checks++;
    if (kill_mask !== 17'h00008 || score !== 16'd1) begin
      n_fail++;
      $display("FAIL kill_3: mask=%h score=%0d required 00008/1", kill_mask, score);
    end
    step();
    n_checks++;
    if (kill_mask !== 17'h00008 || score !== 16'd1) begin
      n_fail++;
      $display("FAIL kill_dup: mask=%h score=%0d required 00008/1", kill_mask, score);
    end
    kill_idx = 5'd20;
    step();
    kill_valid = 1'b0;
    n_checks++;
    if (kill_mask !== 17'h00008 || score !== 16'd1) begin
      n_fail++;
      $display("FAIL kill_range: mask=%h score=%0d required 00008/1", kill_mask, score);
    end
  endtask

  task automatic test_escape();
    fly_alive_flat = 17'h1FFFC;
    step();
    n_checks++;
    if (lives !== 2'd1 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL escape_two: lives=%0d state=%0d required 1/3", lives, state);
    end
    fly_alive_flat = 17'h1FFF8;
    step();
    n_checks++;
    if (lives !== 2'd0 || state !== 3'd5 || game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL escape_over: lives=%0d state=%0d go=%b required 0/5/1",
               lives, state, game_over);
    end
    fly_alive_flat = 17'h00000;
    repeat (3) step();
    n_checks++;
    if (state !== 3'd5 || score !== 16'd1 || kill_mask !== 17'h00008 || move_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL over_frozen: state=%0d score=%0d mask=%h mt=%b required 5/1/00008/0",
               state, score, kill_mask, move_tick);
    end
  endtask

  task automatic test_clear();
    fly_alive_flat = ALL;
    start          = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (state !== 3'd1 || score !== 16'd0 || lives !== 2'd3 || wave !== 4'd0) begin
      n_fail++;
      $display("FAIL restart_init: state=%0d score=%0d lives=%0d wave=%0d required 1/0/3/0",
               state, score, lives, wave);
    end
    step();
    n_checks++;
    if (kill_mask !== 17'd0) begin
      n_fail++;
      $display("FAIL mask_cleared: mask=%h required 00000", kill_mask);
    end
    step();
    clear_wave(4'd1);
    check_period(12);
  endtask

  task automatic test_period_clamp();
    clear_wave(4'd2);
    check_period(8);
    clear_wave(4'd3);
    check_period(8);
  endtask

  task automatic test_simul_kill();
    kill_valid = 1'b1;
    kill_idx   = 5'd5;
    step();
    kill_valid     = 1'b0;
    fly_alive_flat = 17'h1FFDF;
    step();
    n_checks++;
    if (score !== 16'd52 || lives !== 2'd3 || kill_mask !== 17'h00020) begin
      n_fail++;
      $display("FAIL simul_kill: score=%0d lives=%0d mask=%h required 52/3/00020",
               score, lives, kill_mask);
    end
    step();
    n_checks++;
    if (lives !== 2'd3 || state !== 3'd3) begin
      n_fail++;
      $display("FAIL simul_no_escape: lives=%0d state=%0d required 3/3", lives, state);
    end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    #2;
    n_checks++;
    if ({state, reset_fly, move_tick, kill_mask, wave, score, lives, game_over} !==
        {3'd0, 1'b0, 1'b0, 17'd0, 4'd0, 16'd0, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d rf=%b mt=%b mask=%h wave=%0d score=%0d lives=%0d go=%b",
               state, reset_fly, move_tick, kill_mask, wave, score, lives, game_over);
    end
    step();
    reset_n        = 1'b1;
    fly_alive_flat = ALL;
    repeat (3) step();
    n_checks++;
    if (state !== 3'd0 || reset_fly !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: state=%0d reset_fly=%b required 0/0", state, reset_fly);
    end
  endtask

  task automatic test_bonus_life();
    logic [1:0] exp_bonus;
`ifdef FLY_SCHED_BONUS_LIFE_EN
    exp_bonus = 2'd3;
`else
    exp_bonus = 2'd2;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    fly_alive_flat = 17'h1FFFE;
    step();
    n_checks++;
    if (lives !== 2'd2) begin
      n_fail++;
      $display("FAIL bonus_setup: lives=%0d required=2", lives);
    end
    clear_wave(4'd1);
    n_checks++;
    if (lives !== 2'd2) begin
      n_fail++;
      $display("FAIL bonus_escaped_wave: lives=%0d required=2", lives);
    end
    step();
    step();
    clear_wave(4'd2);
    n_checks++;
    if (lives !== exp_bonus) begin
      n_fail++;
      $display("FAIL bonus_clean_wave: lives=%0d required=%0d", lives, exp_bonus);
    end
    step();
    step();
    clear_wave(4'd3);
    n_checks++;
    if (lives !== exp_bonus) begin
      n_fail++;
      $display("FAIL bonus_saturate: lives=%0d required=%0d", lives, exp_bonus);
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_kill();
    test_escape();
    test_clear();
    test_period_clamp();
    test_simul_kill();
    test_reset_mid();
    test_bonus_life();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
